count_arbiter: RTL and testbench
================================

# count_arbiter

Shared LED-counter arbiter for the icestick status display. Up to NUM_REQ requesters each ask for one count run with its own terminal value. The block grants the single counter to one requester at a time in round-robin order and advances it at a divided tick rate. It pulses a per-requester done when the run completes, and the counter drives the board LEDs directly. The block replaces the derived-clock counter style: everything runs on clk with a clock-enable tick.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 4, counter/LED width
- TICK_DIV, 1500000, clk cycles per count step (≥2)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  level requests, synchronous to clk, active-high
- limit  in  NUM_REQ*CNT_W  terminal count per requester; slice i = limit[i*CNT_W +: CNT_W]
- grant  out  NUM_REQ  one-hot owner of the counter, registered
- count  out  CNT_W  counter value (drives LEDs), registered
- busy  out  1  high in COUNT and DONE
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester

## Operation
- Reset values: grant=0, count=0, busy=0, done=0, state=IDLE, rr pointer=0, divider=0.
- States: IDLE, COUNT, DONE; illegal encoding -> IDLE next edge.
- IDLE: if any req is set, select the winner by round robin starting at pointer p. Index p has highest priority, then p+1, wrapping modulo NUM_REQ.
  - Same edge: grant<=onehot(winner), latch limit slice into lim_q, count<=0, divider<=0, busy<=1, state<=COUNT, p<=(winner+1) mod NUM_REQ.
- COUNT: divider increments each cycle. tick = (divider==TICK_DIV-1); on tick divider<=0.
  - On tick with count!=lim_q: count<=count+1.
  - On tick with count==lim_q: state<=DONE, done<=grant.
  - Run length is (lim_q+1)*TICK_DIV cycles. lim_q=0 gives one tick. lim_q=2^CNT_W-1 never wraps count.
  - limit changes after grant are ignored, because the value is latched.
- DONE: lasts exactly one cycle. Next edge: done<=0, grant<=0, busy<=0, count<=0, state<=IDLE.
- Requests from non-granted requesters are ignored until IDLE. A granted requester that keeps req high re-competes and gets lowest priority.
- Request drop mid-run: see Configuration.
- Async rst at any point, including mid-run: immediately forces all reset values. No done pulse is issued.

## Timing
- req sampled high at edge k in IDLE -> grant and busy high after edge k.
- count first increments at edge k+TICK_DIV.
- The DONE transition happens at edge k+(lim_q+1)*TICK_DIV; done is high for the following cycle only.
- grant, busy and count clear one edge after DONE entry. The earliest next grant is the edge after that, so the minimum gap is 1 IDLE cycle between runs.
- Simultaneous requests in IDLE: exactly one grant, and grant is never more than one-hot.

## Configuration
- COUNT_ARB_ABORT_EN defined: if req[owner] is low at any COUNT edge, the run aborts.
  - That edge: state<=IDLE, grant<=0, busy<=0, count<=0, no done pulse.
  - Pointer remains as advanced at grant.
  - Abort has priority over a coincident terminal tick.
- Undefined: req is ignored after grant and every granted run completes with a done pulse.

## Test plan
- TICK_DIV=4, req=0001, limit[0]=3, req held: grant=0001 after edge k; count 1,2,3 at k+4,k+8,k+12; done=0001 for one cycle after k+16; grant=0 after k+17.
- req=1111 held, all limits 0: grants in order 0001,0010,0100,1000,0001. Each run lasts 4 cycles plus DONE, with 1 IDLE cycle between runs.
- limit=4'hF, TICK_DIV=2: count reaches 15 and holds (no wrap); done after 32 cycles.
- Assert rst mid-COUNT with count=2: all outputs 0 immediately; no done. After release, req=0100 is granted next (pointer=0 scan).
- With COUNT_ARB_ABORT_EN, drop req[1] at count=1: IDLE next edge, done never pulses. Without the macro the same stimulus completes with done=0010.
- Change limit[0] from 3 to 1 mid-run: the run still ends at count=3.

Source files
------------

// File: rtl/count_arbiter.sv
// Round-robin arbiter sharing one tick-driven LED counter among NUM_REQ requesters.
// Optional build macro COUNT_ARB_ABORT_EN: a run aborts when its owner drops req.
module count_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int CNT_W    = 4,
   parameter int TICK_DIV = 1500000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] limit,
   output logic [NUM_REQ-1:0]       grant,
   output logic [CNT_W-1:0]         count,
   output logic                     busy,
   output logic [NUM_REQ-1:0]       done
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int DIV_W = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [CNT_W-1:0]     lim_q, lim_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic                 busy_q, busy_d;

   logic [CNT_W-1:0]     lim_arr [NUM_REQ];
   logic [PTR_W:0]       rr_sum;
   logic [PTR_W-1:0]     win_idx;
   logic                 any_req;
   logic                 tick;
   logic                 abort;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lim
      assign lim_arr[g] = limit[g*CNT_W +: CNT_W];
   end

   assign tick = (div_q == DIV_W'(TICK_DIV - 1));

`ifdef COUNT_ARB_ABORT_EN
   assign abort = ~|(req & grant_q);
`else
   assign abort = 1'b0;
`endif

   // Scan from ptr_q upward, wrapping modulo NUM_REQ; the first set req wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
      any_req = 1'b0;
      win_idx = '0;
      rr_sum  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rr_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (rr_sum >= (PTR_W+1)'(NUM_REQ)) rr_sum = rr_sum - (PTR_W+1)'(NUM_REQ);
         if (!any_req && req[rr_sum[PTR_W-1:0]]) begin
            any_req = 1'b1;
            win_idx = rr_sum[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = '0;
      count_d = count_q;
      lim_d   = lim_q;
      div_d   = div_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               grant_d = NUM_REQ'(1) << win_idx;
               lim_d   = lim_arr[win_idx];
               count_d = '0;
               div_d   = '0;
               busy_d  = 1'b1;
               state_d = S_COUNT;
               ptr_d   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
         end
         S_COUNT: begin
            // Abort outranks a coincident terminal tick and issues no done pulse.
            if (abort) begin
               state_d = S_IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
               count_d = '0;
               div_d   = '0;
            end else if (tick) begin
               div_d = '0;
               if (count_q == lim_q) begin
                  state_d = S_DONE;
                  done_d  = grant_q;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            count_d = '0;
            div_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            count_d = '0;
            div_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         done_q  <= '0;
         count_q <= '0;
         lim_q   <= '0;
         div_q   <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         count_q <= count_d;
         lim_q   <= lim_d;
         div_q   <= div_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign count = count_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter: dut_a runs with TICK_DIV=4, dut_b with TICK_DIV=2.
// Expectations adapt to the COUNT_ARB_ABORT_EN build macro.
module tb_count_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] limit;

   logic [3:0]  a_grant, a_count, a_done;
   logic        a_busy;
   logic [3:0]  b_grant, b_count, b_done;
   logic        b_busy;

   int n_checks = 0;
   int n_pass   = 0;

   count_arbiter #(.NUM_REQ(4), .CNT_W(4), .TICK_DIV(4)) dut_a (
      .clk(clk), .rst(rst), .req(req), .limit(limit),
      .grant(a_grant), .count(a_count), .busy(a_busy), .done(a_done)
   );

   count_arbiter #(.NUM_REQ(4), .CNT_W(4), .TICK_DIV(2)) dut_b (
      .clk(clk), .rst(rst), .req(req), .limit(limit),
      .grant(b_grant), .count(b_count), .busy(b_busy), .done(b_done)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      logic done_seen;
      rst   = 1'b1;
      req   = 4'b0000;
      limit = 16'h0000;
      step(2);
      check("rst_grant", 32'(a_grant), 32'h0);
      check("rst_count", 32'(a_count), 32'h0);
      check("rst_busy",  32'(a_busy),  32'h0);
      check("rst_done",  32'(a_done),  32'h0);

      // Single run, limit 3, with limit changed to 1 mid-run.
      rst   = 1'b0;
      req   = 4'b0001;
      limit = 16'h0003;
      step(1);
      check("t1_grant_k",  32'(a_grant), 32'h1);
      check("t1_busy_k",   32'(a_busy),  32'h1);
      check("t1_count_k",  32'(a_count), 32'h0);
      step(3);
      check("t1_count_k3", 32'(a_count), 32'h0);
      step(1);
      check("t1_count_k4", 32'(a_count), 32'h1);
      step(4);
      check("t1_count_k8", 32'(a_count), 32'h2);
      limit = 16'h0001;
      step(4);
      check("t1_count_k12", 32'(a_count), 32'h3);
      check("t1_done_k12",  32'(a_done),  32'h0);
      step(3);
      check("t1_count_k15", 32'(a_count), 32'h3);
      check("t1_done_k15",  32'(a_done),  32'h0);
      step(1);
      check("t1_done_k16",  32'(a_done),  32'h1);
      check("t1_grant_k16", 32'(a_grant), 32'h1);
      check("t1_busy_k16",  32'(a_busy),  32'h1);
      step(1);
      check("t1_done_k17",  32'(a_done),  32'h0);
      check("t1_grant_k17", 32'(a_grant), 32'h0);
      check("t1_busy_k17",  32'(a_busy),  32'h0);
      check("t1_count_k17", 32'(a_count), 32'h0);

      // Held req re-grants after one idle cycle; then reset mid-run at count 2.
      limit = 16'h0002;
      step(1);
      check("t4_regrant", 32'(a_grant), 32'h1);
      step(8);
      check("t4_count2", 32'(a_count), 32'h2);
      #1 rst = 1'b1;
      #1;
      check("t4_rst_grant", 32'(a_grant), 32'h0);
      check("t4_rst_count", 32'(a_count), 32'h0);
      check("t4_rst_busy",  32'(a_busy),  32'h0);
      check("t4_rst_done",  32'(a_done),  32'h0);
      step(3);
      check("t4_rst_done_held", 32'(a_done), 32'h0);
      // Pointer must be back at 0: with req 0101 requester 0 wins, not 2.
      req = 4'b0101;
      rst = 1'b0;
      step(1);
      check("t4_ptr_reset", 32'(a_grant), 32'h1);

      // All four requesting, all limits 0: strict rotation, 6-cycle period.
      rst   = 1'b1;
      req   = 4'b0000;
      limit = 16'h0000;
      step(1);
      rst = 1'b0;
      req = 4'b1111;
      step(1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t2_grant_%0d", i), 32'(a_grant), 32'h1 << (i % 4));
         step(4);
         check($sformatf("t2_done_%0d", i),  32'(a_done),  32'h1 << (i % 4));
         step(1);
         check($sformatf("t2_gap_%0d", i),   32'(a_grant), 32'h0);
         step(1);
      end

      // Requester 1 drops req at count 1.
      rst = 1'b1;
      req = 4'b0000;
      step(1);
      rst   = 1'b0;
      req   = 4'b0010;
      limit = 16'h0030;
      step(1);
      check("t5_grant", 32'(a_grant), 32'h2);
      step(4);
      check("t5_count1", 32'(a_count), 32'h1);
      req = 4'b0000;
      step(1);
`ifdef COUNT_ARB_ABORT_EN
      check("t5_abort_grant", 32'(a_grant), 32'h0);
      check("t5_abort_busy",  32'(a_busy),  32'h0);
      check("t5_abort_count", 32'(a_count), 32'h0);
      done_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         done_seen = done_seen | (|a_done);
         step(1);
      end
      check("t5_abort_no_done", 32'(done_seen), 32'h0);
`else
      check("t5_keep_grant", 32'(a_grant), 32'h2);
      check("t5_keep_busy",  32'(a_busy),  32'h1);
      step(11);
      check("t5_done",       32'(a_done),  32'h2);
      check("t5_done_count", 32'(a_count), 32'h3);
      step(1);
      check("t5_done_clear", 32'(a_done),  32'h0);
      check("t5_grant_clear", 32'(a_grant), 32'h0);
`endif

      // Full-scale limit on dut_b (TICK_DIV=2): count holds at 15, done at k+32.
      rst = 1'b1;
      step(1);
      rst   = 1'b0;
      req   = 4'b0001;
      limit = 16'h000F;
      step(1);
      check("t3_grant", 32'(b_grant), 32'h1);
      step(30);
      check("t3_count_k30", 32'(b_count), 32'hF);
      step(1);
      check("t3_count_k31", 32'(b_count), 32'hF);
      check("t3_done_k31",  32'(b_done),  32'h0);
      step(1);
      check("t3_done_k32",  32'(b_done),  32'h1);
      check("t3_count_k32", 32'(b_count), 32'hF);
      step(1);
      check("t3_done_k33",  32'(b_done),  32'h0);
      check("t3_count_k33", 32'(b_count), 32'h0);
      check("t3_grant_k33", 32'(b_grant), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
